// File: rtl/rv32i_cpu_core.sv
// +----------------------------------------------------------------------------+
// | Module      : rv32i_cpu_core (with submodule rv32i_regfile)                  |
// | Description : Single-cycle RV32I core with internal imem/dmem and regfile.  |
// |               Optional macro ILLEGAL_HALT_EN halts on unrecognised encodings.|
// | Revision    : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module rv32i_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   input  logic        we,
   input  logic [4:0]  rd_addr,
   input  logic [31:0] rd_data
);
   logic [31:0] regs [0:31];

   assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
   assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && (rd_addr != 5'd0)) begin
         regs[rd_addr] <= rd_data;
      end
   end
endmodule

module rv32i_cpu_core #(
   parameter int IMEM_WORDS = 256,
   parameter int DMEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   output logic        halted,
   output logic [31:0] pc
);
   localparam int IW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
   localparam int DW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

   localparam logic [6:0]  c_op_lui    = 7'h37;
   localparam logic [6:0]  c_op_auipc  = 7'h17;
   localparam logic [6:0]  c_op_jal    = 7'h6f;
   localparam logic [6:0]  c_op_jalr   = 7'h67;
   localparam logic [6:0]  c_op_branch = 7'h63;
   localparam logic [6:0]  c_op_load   = 7'h03;
   localparam logic [6:0]  c_op_store  = 7'h23;
   localparam logic [6:0]  c_op_imm    = 7'h13;
   localparam logic [6:0]  c_op_reg    = 7'h33;
   localparam logic [6:0]  c_op_fence  = 7'h0f;
   localparam logic [6:0]  c_op_system = 7'h73;
   localparam logic [31:0] c_ecall     = 32'h0000_0073;
   localparam logic [31:0] c_ebreak    = 32'h0010_0073;

   logic [31:0] imem [0:IMEM_WORDS-1];
   logic [31:0] dmem [0:DMEM_WORDS-1];

   logic [31:0] pc_q, pc_d;
   logic        halted_q, halted_d;

   logic [IW-1:0] imem_idx;
   logic [31:0]   inst;
   logic [6:0]    opcode, f7;
   logic [2:0]    f3;
   logic [4:0]    rd, rs1, rs2;
   logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0]   rs1_val, rs2_val;

   assign imem_idx = IW'(pc_q[31:2] % 30'(IMEM_WORDS));
   assign inst     = imem[imem_idx];
   assign opcode   = inst[6:0];
   assign rd       = inst[11:7];
   assign f3       = inst[14:12];
   assign rs1      = inst[19:15];
   assign rs2      = inst[24:20];
   assign f7       = inst[31:25];

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'd0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   logic        rf_we;
   logic [31:0] rd_wdata;

   rv32i_regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .rs1_addr (rs1),
      .rs2_addr (rs2),
      .rs1_data (rs1_val),
      .rs2_data (rs2_val),
      .we       (rf_we),
      .rd_addr  (rd),
      .rd_data  (rd_wdata)
   );

   logic [31:0] alu_b, alu_y;
   logic [4:0]  shamt;

   always_comb begin
      alu_b = (opcode == c_op_reg) ? rs2_val : imm_i;
      shamt = alu_b[4:0];
      alu_y = '0;
      case (f3)
         3'd0: alu_y = (opcode == c_op_reg && f7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
         3'd1: alu_y = rs1_val << shamt;
         3'd2: alu_y = {31'd0, $signed(rs1_val) < $signed(alu_b)};
         3'd3: alu_y = {31'd0, rs1_val < alu_b};
         3'd4: alu_y = rs1_val ^ alu_b;
         3'd5: alu_y = f7[5] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
         3'd6: alu_y = rs1_val | alu_b;
         3'd7: alu_y = rs1_val & alu_b;
         default: alu_y = '0;
      endcase
   end

   logic br_taken;

   always_comb begin
      br_taken = 1'b0;
      case (f3)
         3'd0: br_taken = (rs1_val == rs2_val);
         3'd1: br_taken = (rs1_val != rs2_val);
         3'd4: br_taken = ($signed(rs1_val) <  $signed(rs2_val));
         3'd5: br_taken = ($signed(rs1_val) >= $signed(rs2_val));
         3'd6: br_taken = (rs1_val <  rs2_val);
         3'd7: br_taken = (rs1_val >= rs2_val);
         default: br_taken = 1'b0;
      endcase
   end

   logic [31:0]   mem_addr, mem_rword, load_data, store_data;
   logic [DW-1:0] dmem_idx;
   logic [7:0]    mem_byte;
   logic [15:0]   mem_half;
   logic [3:0]    store_mask;

   assign mem_addr  = rs1_val + ((opcode == c_op_store) ? imm_s : imm_i);
   assign dmem_idx  = DW'(mem_addr[31:2] % 30'(DMEM_WORDS));
   assign mem_rword = dmem[dmem_idx];

   // Halfword at lane 3 only has one byte inside the word; upper byte reads as zero.
   always_comb begin
      mem_byte = mem_rword[7:0];
      mem_half = mem_rword[15:0];
      case (mem_addr[1:0])
         2'd1: begin mem_byte = mem_rword[15:8];  mem_half = mem_rword[23:8];         end
         2'd2: begin mem_byte = mem_rword[23:16]; mem_half = mem_rword[31:16];        end
         2'd3: begin mem_byte = mem_rword[31:24]; mem_half = {8'd0, mem_rword[31:24]}; end
         default: ;
      endcase
      case (f3)
         3'd0:    load_data = {{24{mem_byte[7]}}, mem_byte};
         3'd1:    load_data = {{16{mem_half[15]}}, mem_half};
         3'd4:    load_data = {24'd0, mem_byte};
         3'd5:    load_data = {16'd0, mem_half};
         default: load_data = mem_rword;
      endcase
      case (f3)
         3'd0:    store_mask = 4'b0001 << mem_addr[1:0];
         3'd1:    store_mask = 4'b0011 << mem_addr[1:0];
         default: store_mask = 4'b1111;
      endcase
      store_data = (f3 == 3'd2) ? rs2_val : rs2_val << {mem_addr[1:0], 3'b000};
   end

   logic        legal, sys_halt, halt_now, rd_we, mem_we, commit_en, dmem_we;
   logic [31:0] next_pc;

   always_comb begin
      legal    = 1'b0;
      sys_halt = 1'b0;
      rd_we    = 1'b0;
      mem_we   = 1'b0;
      rd_wdata = alu_y;
      next_pc  = pc_q + 32'd4;
      case (opcode)
         c_op_lui:    begin legal = 1'b1; rd_we = 1'b1; rd_wdata = imm_u; end
         c_op_auipc:  begin legal = 1'b1; rd_we = 1'b1; rd_wdata = pc_q + imm_u; end
         c_op_jal: begin
            legal = 1'b1; rd_we = 1'b1; rd_wdata = pc_q + 32'd4;
            next_pc = pc_q + imm_j;
         end
         c_op_jalr: begin
            legal = (f3 == 3'd0); rd_we = 1'b1; rd_wdata = pc_q + 32'd4;
            next_pc = (rs1_val + imm_i) & ~32'd1;
         end
         c_op_branch: begin
            legal = (f3 != 3'd2) && (f3 != 3'd3);
            if (br_taken) next_pc = pc_q + imm_b;
         end
         c_op_load: begin
            legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            rd_we = 1'b1; rd_wdata = load_data;
         end
         c_op_store: begin legal = (f3 <= 3'd2); mem_we = 1'b1; end
         c_op_imm: begin
            if (f3 == 3'd1)      legal = (f7 == 7'h00);
            else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
            else                 legal = 1'b1;
            rd_we = 1'b1;
         end
         c_op_reg: begin
            legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
            rd_we = 1'b1;
         end
         c_op_fence:  legal = 1'b1;
         c_op_system: begin
            if (inst == c_ecall || inst == c_ebreak) begin
               legal = 1'b1; sys_halt = 1'b1;
            end
         end
         default: ;
      endcase
      // Unrecognised encodings never produce side effects.
      if (!legal) begin
         rd_we = 1'b0; mem_we = 1'b0; next_pc = pc_q + 32'd4;
      end
`ifdef ILLEGAL_HALT_EN
      halt_now = sys_halt || !legal;
`else
      halt_now = sys_halt;
`endif
   end

   always_comb begin
      pc_d      = pc_q;
      halted_d  = halted_q;
      commit_en = !halted_q && !halt_now;
      if (!halted_q) begin
         if (halt_now) halted_d = 1'b1;
         else          pc_d     = next_pc;
      end
   end

   assign rf_we   = commit_en && rd_we;
   assign dmem_we = commit_en && mem_we && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= '0;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         halted_q <= halted_d;
      end
   end

   // Data memory is not reset so its contents survive a core reset.
   always_ff @(posedge clk) begin
      if (dmem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (store_mask[b]) dmem[dmem_idx][b*8 +: 8] <= store_data[b*8 +: 8];
         end
      end
   end

   assign pc     = pc_q;
   assign halted = halted_q;
endmodule

`default_nettype wire

// File: tb/tb_rv32i_cpu_core.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_rv32i_cpu_core                                              |
// | Description : Directed self-checking bench for rv32i_cpu_core.               |
// | Revision    : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rv32i_cpu_core;
   localparam int IMEM_WORDS = 256;
   localparam int DMEM_WORDS = 256;

   localparam logic [6:0] OPI = 7'h13, OPR = 7'h33, LD = 7'h03, ST = 7'h23, BR = 7'h63;
   localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6f, JALR = 7'h67;
   localparam logic [31:0] ECALL = 32'h0000_0073, EBREAK = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        halted;
   logic [31:0] pc;

   int n_assert = 0;
   int n_fail   = 0;
   logic [31:0] prog[$];

   rv32i_cpu_core #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS)) dut (
      .clk    (clk),
      .rst    (rst),
      .halted (halted),
      .pc     (pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rg(input int i);
      return dut.u_regfile.regs[i];
   endfunction

   function automatic logic [31:0] e_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
      logic [31:0] v = imm;
      return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
   endfunction

   function automatic logic [31:0] e_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OPR};
   endfunction

   function automatic logic [31:0] e_s(input int imm, input int rs2, input int rs1, input int f3);
      logic [31:0] v = imm;
      return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], ST};
   endfunction

   function automatic logic [31:0] e_b(input int imm, input int rs2, input int rs1, input int f3);
      logic [31:0] v = imm;
      return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], BR};
   endfunction

   function automatic logic [31:0] e_u(input int imm, input int rd, input logic [6:0] op);
      logic [31:0] v = imm;
      return {v[19:0], 5'(rd), op};
   endfunction

   function automatic logic [31:0] e_j(input int imm, input int rd);
      logic [31:0] v = imm;
      return {v[20], v[10:1], v[11], v[19:12], 5'(rd), JAL};
   endfunction

   task automatic load_prog();
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < IMEM_WORDS; i++)
         dut.imem[i] = (i < prog.size()) ? prog[i] : 32'h0000_0013;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_to_halt(input int budget);
      int k = 0;
      while (!halted && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("halt_reached", {31'd0, halted}, 32'd1);
   endtask

   initial begin
      int nz;

      // Sum 1..5 into x1, store to dmem[0], then ECALL.
      prog.delete();
      prog.push_back(e_i(0, 0, 0, 1, OPI));
      prog.push_back(e_i(5, 0, 0, 2, OPI));
      prog.push_back(e_r(0, 2, 1, 0, 1));
      prog.push_back(e_i(-1, 2, 0, 2, OPI));
      prog.push_back(e_b(-8, 0, 2, 1));
      prog.push_back(e_s(0, 1, 0, 2));
      prog.push_back(ECALL);
      load_prog();
      check("reset_pc", pc, 32'd0);
      check("reset_halted", {31'd0, halted}, 32'd0);
      nz = 0;
      for (int i = 0; i < 32; i++) if (rg(i) !== 32'd0) nz++;
      check("reset_regs_nonzero", 32'(nz), 32'd0);
      rst = 1'b0;
      run_to_halt(100);
      check("sum_x1", rg(1), 32'd15);
      check("sum_dmem0", dut.dmem[0], 32'd15);
      check("sum_halt_pc", pc, 32'h18);

      // Asynchronous reset in the middle of the same program.
      load_prog();
      rst = 1'b0;
      step(3);
      check("pre_rst_pc", pc, 32'h0c);
      check("pre_rst_x2", rg(2), 32'd5);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_pc", pc, 32'd0);
      check("async_rst_x2", rg(2), 32'd0);
      check("async_rst_halted", {31'd0, halted}, 32'd0);
      check("dmem_retained", dut.dmem[0], 32'd15);

      // ALU and immediates.
      prog.delete();
      prog.push_back(e_i(-1, 0, 0, 2, OPI));
      prog.push_back(e_i(28, 2, 5, 3, OPI));
      prog.push_back(e_i(32'h404, 2, 5, 4, OPI));
      prog.push_back(e_r(0, 2, 0, 3, 5));
      prog.push_back(e_r(0, 0, 2, 2, 6));
      prog.push_back(e_u(32'h12345, 7, LUI));
      prog.push_back(e_i(5, 0, 0, 0, OPI));
      prog.push_back(e_i(100, 0, 0, 8, OPI));
      prog.push_back(e_r(32'h20, 2, 8, 0, 9));
      prog.push_back(e_i(255, 8, 4, 10, OPI));
      prog.push_back(e_u(1, 11, AUIPC));
      prog.push_back(e_r(0, 8, 3, 1, 12));
      prog.push_back(ECALL);
      load_prog();
      rst = 1'b0;
      run_to_halt(100);
      check("srli_x3", rg(3), 32'h0000_000f);
      check("srai_x4", rg(4), 32'hffff_ffff);
      check("sltu_x5", rg(5), 32'd1);
      check("slt_x6", rg(6), 32'd1);
      check("lui_x7", rg(7), 32'h1234_5000);
      check("x0_zero", rg(0), 32'd0);
      check("sub_x9", rg(9), 32'd101);
      check("xori_x10", rg(10), 32'h0000_009b);
      check("auipc_x11", rg(11), 32'h0000_1028);
      check("sll_x12", rg(12), 32'h0000_00f0);
      check("alu_halt_pc", pc, 32'h30);

      // Byte and halfword memory accesses.
      prog.delete();
      prog.push_back(e_u(32'h80ff8, 1, LUI));
      prog.push_back(e_i(-255, 1, 0, 1, OPI));
      prog.push_back(e_s(8, 1, 0, 2));
      prog.push_back(e_i(8, 0, 0, 2, LD));
      prog.push_back(e_i(11, 0, 0, 3, LD));
      prog.push_back(e_i(11, 0, 4, 4, LD));
      prog.push_back(e_i(10, 0, 1, 5, LD));
      prog.push_back(e_i(170, 0, 0, 6, OPI));
      prog.push_back(e_s(9, 6, 0, 0));
      prog.push_back(e_i(8, 0, 5, 7, LD));
      prog.push_back(e_i(8, 0, 2, 8, LD));
      prog.push_back(e_s(10, 6, 0, 1));
      prog.push_back(e_i(8, 0, 2, 9, LD));
      prog.push_back(ECALL);
      load_prog();
      rst = 1'b0;
      run_to_halt(100);
      check("sw_value_x1", rg(1), 32'h80ff_7f01);
      check("lb_8", rg(2), 32'h0000_0001);
      check("lb_11", rg(3), 32'hffff_ff80);
      check("lbu_11", rg(4), 32'h0000_0080);
      check("lh_10", rg(5), 32'hffff_80ff);
      check("lhu_8", rg(7), 32'h0000_aa01);
      check("sb_9_word", rg(8), 32'h80ff_aa01);
      check("sh_10_word", rg(9), 32'h00aa_aa01);
      check("dmem2", dut.dmem[2], 32'h00aa_aa01);

      // Control flow, then halt hold after EBREAK.
      prog.delete();
      prog.push_back(e_i(-1, 0, 0, 2, OPI));
      prog.push_back(e_i(1, 0, 0, 3, OPI));
      prog.push_back(e_b(8, 3, 2, 4));
      prog.push_back(e_i(99, 0, 0, 10, OPI));
      prog.push_back(e_j(8, 1));
      prog.push_back(e_j(12, 0));
      prog.push_back(e_i(1, 1, 0, 0, JALR));
      prog.push_back(e_i(77, 0, 0, 11, OPI));
      prog.push_back(e_b(8, 3, 2, 6));
      prog.push_back(e_i(5, 0, 0, 12, OPI));
      prog.push_back(e_s(16, 2, 0, 2));
      prog.push_back(EBREAK);
      prog.push_back(e_s(16, 3, 0, 2));
      prog.push_back(e_i(1, 0, 0, 13, OPI));
      load_prog();
      rst = 1'b0;
      step(3);
      check("blt_taken_pc", pc, 32'h10);
      step(1);
      check("jal_pc", pc, 32'h18);
      check("jal_link_x1", rg(1), 32'h14);
      step(1);
      check("jalr_pc", pc, 32'h14);
      step(1);
      check("jal_fwd_pc", pc, 32'h20);
      step(1);
      check("bltu_untaken_pc", pc, 32'h24);
      run_to_halt(20);
      check("ebreak_pc", pc, 32'h2c);
      check("skipped_x10", rg(10), 32'd0);
      check("skipped_x11", rg(11), 32'd0);
      check("x12_set", rg(12), 32'd5);
      check("dmem4_before_halt", dut.dmem[4], 32'hffff_ffff);
      step(10);
      check("hold_pc", pc, 32'h2c);
      check("hold_halted", {31'd0, halted}, 32'd1);
      check("hold_x13", rg(13), 32'd0);
      check("hold_x12", rg(12), 32'd5);
      check("hold_dmem4", dut.dmem[4], 32'hffff_ffff);

      // Unrecognised instruction word.
      prog.delete();
      prog.push_back(e_i(1, 0, 0, 1, OPI));
      prog.push_back(32'hffff_ffff);
      prog.push_back(e_i(2, 0, 0, 2, OPI));
      prog.push_back(ECALL);
      load_prog();
      rst = 1'b0;
      run_to_halt(20);
      check("illegal_x1", rg(1), 32'd1);
`ifdef ILLEGAL_HALT_EN
      check("illegal_halt_pc", pc, 32'h04);
      check("illegal_x2", rg(2), 32'd0);
`else
      check("illegal_nop_pc", pc, 32'h0c);
      check("illegal_x2", rg(2), 32'd2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/rv32i_cpu_core.md
Name: rv32i_cpu_core

Overview:
- Single-cycle RV32I integer core with internal word-organised instruction and data memories and a 32x32 register file; one instruction retires per clock.
- Top-level compute block of the design: no external bus.
- Programs are loaded into instruction memory by hierarchical preload (e.g. memory-file load) while reset is held.
- Execution stops when the core reaches a halt instruction.

Parameters:
- IMEM_WORDS, 256, depth of instruction memory in 32-bit words (array named imem, index 0..IMEM_WORDS-1).
- DMEM_WORDS, 256, depth of data memory in 32-bit words (array named dmem, index 0..DMEM_WORDS-1).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- halted  output  1  high once a halt instruction has executed; stays high until reset.
- pc  output  32  current program counter (byte address of the instruction being executed).

Behaviour:
- Reset (rst=1, async): pc=0, halted=0, all registers regs[0..31]=0. dmem is not cleared; imem is never written by the core.
- Register file: submodule instance u_regfile with array regs[0:31].
  - Two combinational read ports, one write port on clk.
  - x0 reads 0 and writes to it are discarded.
- Fetch: instruction = imem[pc[31:2]] modulo IMEM_WORDS; pc[1:0] ignored.
- Execute in one cycle; at the clock edge, write rd, perform any store, and update pc.
- Instructions supported:
  - LUI, AUIPC, JAL, JALR (target &~1), BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LB, LH, LW, LBU, LHU, SB, SH, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Arithmetic wraps modulo 2^32. Shift amount is the low 5 bits. SLT is signed; SLTU is unsigned.
- Immediates are sign-extended per the I/S/B/U/J formats.
- FENCE executes as a NOP.
- Data memory: word index addr[31:2] modulo DMEM_WORDS.
  - Sub-word stores write only the selected byte lanes (little-endian, lane from addr[1:0]).
  - Loads are combinational; sub-word loads extract the lane and sign- or zero-extend.
  - Misaligned halfword/word accesses use addr[1:0] lane selection with no trap (word ops ignore addr[1:0]).
- Halt: ECALL (0x00000073) or EBREAK (0x00100073).
  - On that cycle's edge, halted is set and pc holds at the halt instruction.
  - While halted: no register or memory writes and pc frozen.
- Undefined opcodes execute as NOPs (pc+4) unless the optional feature is enabled.
- Reset asserted mid-execution: immediate return to reset state; dmem contents retained.

Optional Feature:
- Macro ILLEGAL_HALT_EN.
  - Defined: any unrecognised opcode/funct combination sets halted, and pc holds at the offending instruction, exactly like ECALL.
  - Undefined: such instructions are NOPs and pc advances by 4.

Test Plan:
- Sum loop: with rst held, preload a program that sums 1..5 into x1 (loop with BNE), stores x1 via SW to address 0, then ECALL; release rst -> halted rises; regs[1]=15 and dmem[0]=15.
- Reset state: hold rst high for 2 cycles -> pc=0, halted=0, regs all 0; assert rst mid-program -> pc returns to 0 asynchronously.
- ALU/immediates:
  - ADDI x2,x0,-1 then SRLI x3,x2,28 -> x3=0xF.
  - SRAI x4,x2,4 -> 0xFFFFFFFF.
  - SLTU x5,x0,x2 -> 1; SLT x6,x2,x0 -> 1.
  - LUI x7,0x12345 -> 0x12345000.
  - ADDI x0,x0,5 -> x0 stays 0.
- Byte/half memory:
  - SW 0x80FF7F01 to addr 8.
  - LB from addr 8 -> 0x00000001; LB from addr 11 -> 0xFFFFFF80; LBU from addr 11 -> 0x80; LH from addr 10 -> 0xFFFF80FF.
  - SB 0xAA to addr 9 -> word = 0x80FFAA01.
- Control flow:
  - JAL x1,+8 from pc 0x10 -> x1=0x14, pc=0x18.
  - JALR x0,x1,1 -> pc=0x14.
  - Taken BLT with -1<1 and untaken BLTU with 0xFFFFFFFF<1 go to the correct targets.
- Halt hold: after EBREAK, run 10 more cycles -> pc unchanged, registers and dmem unchanged, halted=1; with ILLEGAL_HALT_EN, word 0xFFFFFFFF -> halted=1.
